serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal values 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on clk.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on an accepted start.
REQ-007 Port: bin  input  1  borrow-in; sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  borrow-out of the MSB stage.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 A start SHALL be accepted only in IDLE or DONE. An accepted start loads a, b and bin into internal registers, clears the bit counter and enters RUN.
REQ-014 In RUN, each cycle SHALL process one bit, LSB first:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d is shifted into the result register from the MSB end.
REQ-015 RUN SHALL last exactly WIDTH cycles. The counter wraps from WIDTH-1 to 0 and the FSM enters DONE on that cycle.
REQ-016 Latency: if start is accepted at edge N, done SHALL be high for exactly the cycle following edge N+WIDTH.
REQ-017 busy SHALL be high from edge N through edge N+WIDTH, and low in IDLE and DONE.
REQ-018 diff and bout SHALL update together at the RUN-to-DONE transition and hold until the next transition into DONE.
REQ-019 From DONE, the FSM SHALL enter RUN if start is high, otherwise IDLE. This allows back-to-back operations with no idle cycle.
REQ-020 start while in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-021 Input changes on a, b and bin outside an accepted start SHALL NOT affect the operation in progress.

Reset
REQ-022 Asserting rst SHALL force, independent of clk:
  - state to IDLE
  - counter, operand registers and borrow to 0
  - busy=0, done=0, diff=0, bout=0
REQ-023 Asserting rst mid-RUN SHALL abort the operation with no done pulse. The first start after rst deassertion behaves as from power-up.

Configuration
REQ-024 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, the block SHALL add output port ovf (1 bit).
  - ovf = borrow into the MSB stage XOR bout.
  - ovf flags signed two's-complement overflow.
  - ovf updates and holds with diff; it resets to 0.
REQ-025 When SERIAL_SUBTRACTOR_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8)
REQ-026 a=0x05, b=0x03, bin=0, start at edge N -> done at cycle after edge N+8, diff=0x02, bout=0.
REQ-027 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-028 start held high continuously with a=0x10, b=0x01 -> results every 9 cycles, diff=0x0F each time; start pulses during RUN are ignored.
REQ-029 rst asserted 4 cycles into RUN -> busy, done, diff and bout are 0 immediately, with no done pulse; the next start (0x09-0x04) gives diff=0x05.
REQ-030 With SERIAL_SUBTRACTOR_OVF_EN defined: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0x01 -> diff=0x7E, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH cycles using an IDLE/RUN/DONE FSM.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, d_bit, br_next, last_bit, load;

    // Operands shift right each RUN cycle so bit 0 is always the bit being processed.
    assign a_bit    = a_q[0];
    assign b_bit    = b_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign load     = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    // Publish the finished word; diff/bout hold here until the next completion.
                    cnt_d   = '0;
                    state_d = DONE;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d   = br_q ^ br_next;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
